alu_op_sequencer: RTL
=====================

Name: alu_op_sequencer

Overview:
Multi-cycle controller that fronts the 32-bit gate-delay ALU datapath (ripple adder/subtractor plus bitwise AND/NAND/OR/NOR/XOR/NOT arrays). Accepts one operation at a time over a valid/ready request channel and drives registered operands and opcode into the combinational ALU. Waits a fixed settle time for the ripple chain to resolve, then captures result, carryout, overflow and the zero flag into a valid/ready response channel. SLT is synthesised here from the ALU subtract path; the zero flag is generated here.

Parameters:
SETTLE_CYCLES, 4, clock cycles the ALU inputs are held before capture; legal range 1..255
CNT_W, 8, settle counter width; must hold SETTLE_CYCLES-1

Ports:
clk  in  1  single clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid && req_ready at clk edge
req_op  in  3  opcode (see package)
req_a  in  32  operand A
req_b  in  32  operand B
alu_a  out  32  registered operand A to ALU
alu_b  out  32  registered operand B to ALU
alu_op  out  3  registered ALU opcode (SLT is driven as SUB)
alu_res  in  32  ALU result
alu_carryout  in  1  ALU carryout
alu_overflow  in  1  ALU overflow
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready at clk edge
rsp_result  out  32  captured result
rsp_carryout  out  1  captured carryout (0 for non-arith ops)
rsp_overflow  out  1  captured overflow (0 for non-arith ops and SLT)
rsp_zero  out  1  1 when rsp_result == 0
busy  out  1  state != IDLE

Behaviour:
- Reset (async, any time incl. mid-operation): state=IDLE, counter=0, alu_a/alu_b/alu_op=0, all rsp_* = 0, busy=0. req_ready=0 while reset is high.
- States: IDLE, SETTLE, DONE.
- req_ready = (state==IDLE) || (state==DONE && rsp_ready). Combinational, no dependence on req_valid.
- IDLE: on accept, register req_a->alu_a, req_b->alu_b, opcode mapped to alu_op (SLT->SUB); save the original op in op_q; counter=SETTLE_CYCLES-1; go SETTLE.
- SETTLE: alu_a/alu_b/alu_op held stable. If counter!=0, decrement. If counter==0, capture into rsp_* and go DONE with rsp_valid=1.
- Latency: rsp_valid rises exactly SETTLE_CYCLES edges after the accepting edge. SETTLE_CYCLES=1 gives capture on the first edge after accept.
- Capture rules by op_q:
  - ADD/SUB: result=alu_res; carryout and overflow passed through.
  - SLT: result={31'b0, alu_res[31] ^ alu_overflow}; carryout=0; overflow=0.
  - XOR/AND/NAND/NOR/OR: result=alu_res; carryout=0; overflow=0.
  - rsp_zero computed from the final masked result, registered with it.
- DONE: rsp_* held stable while rsp_valid && !rsp_ready.
  - On rsp handshake with no new accept: rsp_valid=0 and go IDLE. rsp_result etc. hold their last value and are don't-care while rsp_valid=0.
  - On rsp handshake with a simultaneous req accept: rsp_valid=0, load new operands, go SETTLE (back-to-back, no idle bubble).
- req_valid in SETTLE or stalled DONE is ignored (req_ready=0). Requester must hold the request stable until accepted.
- No pipelining: at most one operation in flight.

Decomposition:
- Package alu_pkg:
  - opcode constants OP_ADD=0, OP_SUB=1, OP_XOR=2, OP_SLT=3, OP_AND=4, OP_NAND=5, OP_NOR=6, OP_OR=7.
  - State encoding IDLE=0, SETTLE=1, DONE=2.
  - Function is_arith(op) for ADD/SUB.
- One natural sub-module: alu_settle_timer. It takes load, load_value and enable, and outputs expired (counter==0) while in SETTLE.

Test Plan:
- SETTLE_CYCLES=4; ADD a=0x7FFFFFFF b=0x00000001 -> rsp_valid exactly 4 edges after accept; result=0x80000000, overflow=1, carryout=0, zero=0.
- SUB a=5 b=5 -> result=0, zero=1, carryout=1, overflow=0; alu_op observed as SUB and stable through SETTLE.
- SLT a=0x80000000 b=1 -> result=1, zero=0. SLT a=1 b=0x80000000 -> result=0, zero=1. In both cases alu_op=SUB, carryout=0, overflow=0.
- NAND a=0xFFFF0000 b=0xFF00FF00 -> result=0x00FFFFFF, carryout=0, overflow=0. Hold rsp_ready=0 for 10 cycles: rsp_* stable, req_ready=0, a pending OR request is not accepted. Then raise rsp_ready with req_valid high: the OR is accepted the same edge and rsp_valid drops for 4 cycles.
- Assert reset 2 cycles into SETTLE of an ADD -> immediately busy=0, rsp_valid=0, alu_a=alu_b=0. After deassert req_ready=1, and a fresh XOR a=0xF0F0F0F0 b=0xFFFF0000 -> result=0x0F0FF0F0.
- SETTLE_CYCLES=1 build: ADD 0xFFFFFFFF+1 -> rsp_valid 1 edge after accept, result=0, carryout=1, overflow=0, zero=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode constants, sequencer state encoding and opcode helpers
// for the ALU operation sequencer.
package alu_pkg;

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SUB  = 3'd1;
   localparam logic [2:0] OP_XOR  = 3'd2;
   localparam logic [2:0] OP_SLT  = 3'd3;
   localparam logic [2:0] OP_AND  = 3'd4;
   localparam logic [2:0] OP_NAND = 3'd5;
   localparam logic [2:0] OP_NOR  = 3'd6;
   localparam logic [2:0] OP_OR   = 3'd7;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      DONE   = 2'd2
   } state_t;

   function automatic logic is_arith(input logic [2:0] op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

   // SLT has no datapath opcode of its own; it rides on the subtractor.
   function automatic logic [2:0] alu_opcode(input logic [2:0] op);
      return (op == OP_SLT) ? OP_SUB : op;
   endfunction

endpackage

// File: rtl/alu_settle_timer.sv
// Down-counter that times how long the ALU inputs have been held stable;
// expired is high once the count has reached zero.
module alu_settle_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_value,
   input  logic             enable,
   output logic             expired
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_value;
      end else if (enable && (cnt != '0)) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign expired = (cnt == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle controller in front of the combinational ripple ALU: registers
// one request, waits for the carry chain to settle, then captures the response.
module alu_op_sequencer
   import alu_pkg::*;
#(
   parameter int SETTLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [2:0]  alu_op,
   input  logic [31:0] alu_res,
   input  logic        alu_carryout,
   input  logic        alu_overflow,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_result,
   output logic        rsp_carryout,
   output logic        rsp_overflow,
   output logic        rsp_zero,
   output logic        busy
);

   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

   state_t      state;
   logic [2:0]  op_q;
   logic        accept;
   logic        expired;
   logic [31:0] cap_result;
   logic        cap_carryout;
   logic        cap_overflow;

   assign req_ready = !reset && ((state == IDLE) || ((state == DONE) && rsp_ready));
   assign accept    = req_valid && req_ready;
   assign busy      = (state != IDLE);

   alu_settle_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk        (clk),
      .reset      (reset),
      .load       (accept),
      .load_value (SETTLE_LOAD),
      .enable     (state == SETTLE),
      .expired    (expired)
   );

   // SLT: sign of (a - b) corrected by signed overflow gives a < b.
   always_comb begin
      cap_result   = alu_res;
      cap_carryout = 1'b0;
      cap_overflow = 1'b0;
      if (is_arith(op_q)) begin
         cap_carryout = alu_carryout;
         cap_overflow = alu_overflow;
      end else if (op_q == OP_SLT) begin
         cap_result = {31'b0, alu_res[31] ^ alu_overflow};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         op_q         <= '0;
         alu_a        <= '0;
         alu_b        <= '0;
         alu_op       <= '0;
         rsp_valid    <= 1'b0;
         rsp_result   <= '0;
         rsp_carryout <= 1'b0;
         rsp_overflow <= 1'b0;
         rsp_zero     <= 1'b0;
      end else begin
         if (accept) begin
            alu_a  <= req_a;
            alu_b  <= req_b;
            alu_op <= alu_opcode(req_op);
            op_q   <= req_op;
         end
         case (state)
            IDLE: begin
               if (accept) state <= SETTLE;
            end
            SETTLE: begin
               if (expired) begin
                  rsp_result   <= cap_result;
                  rsp_carryout <= cap_carryout;
                  rsp_overflow <= cap_overflow;
                  rsp_zero     <= (cap_result == '0);
                  rsp_valid    <= 1'b1;
                  state        <= DONE;
               end
            end
            DONE: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= accept ? SETTLE : IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
